// File: rtl/branch_comparator_serial.sv
`default_nettype none
// ============================================================================
// Module   : branch_comparator_serial
// Brief    : MSB-first digit-serial RV32I branch comparator, early-exit on the
//            first differing slice, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module branch_comparator_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             lt,
    output logic             eq,
    output logic             err
);

    localparam int c_N     = WIDTH / DIGIT;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_N - 1);
    localparam logic [WIDTH-1:0]   c_SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_a, r_b, w_a_nxt, w_b_nxt;
    logic [WIDTH-1:0]     w_a_shift, w_b_shift;
    logic [2:0]           r_funct3, w_funct3_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic                 r_out_valid, w_out_valid_nxt;
    logic                 r_taken, w_taken_nxt;
    logic                 r_lt, w_lt_nxt;
    logic                 r_eq, w_eq_nxt;
    logic                 r_err, w_err_nxt;
    logic [DIGIT-1:0]     w_a_slice, w_b_slice;
    logic                 w_signed_in;
    logic                 w_illegal;
    logic                 w_slice_lt;

    function automatic logic f_taken(input logic [2:0] f3, input logic l, input logic e);
        case (f3)
            c_F3_BEQ:             f_taken = e;
            c_F3_BNE:             f_taken = ~e;
            c_F3_BLT, c_F3_BLTU:  f_taken = l;
            c_F3_BGE, c_F3_BGEU:  f_taken = ~l;
            default:              f_taken = 1'b0;
        endcase
    endfunction

    // Captured operands are shifted left each cycle so the slice under test
    // is always the top DIGIT bits; no variable part-select is needed.
    generate
        if (c_N == 1) begin : g_single_slice
            assign w_a_shift = r_a;
            assign w_b_shift = r_b;
        end else begin : g_multi_slice
            assign w_a_shift = {r_a[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
            assign w_b_shift = {r_b[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
        end
    endgenerate

    assign w_a_slice   = r_a[WIDTH-1 -: DIGIT];
    assign w_b_slice   = r_b[WIDTH-1 -: DIGIT];
    assign w_slice_lt  = (w_a_slice < w_b_slice);
    assign w_signed_in = (funct3 == c_F3_BLT) || (funct3 == c_F3_BGE);
    assign w_illegal   = (r_funct3[2:1] == 2'b01);

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign taken     = r_taken;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_funct3    <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_funct3    <= w_funct3_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_taken     <= w_taken_nxt;
            r_lt        <= w_lt_nxt;
            r_eq        <= w_eq_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_funct3_nxt    = r_funct3;
        w_idx_nxt       = r_idx;
        w_out_valid_nxt = r_out_valid;
        w_taken_nxt     = r_taken;
        w_lt_nxt        = r_lt;
        w_eq_nxt        = r_eq;
        w_err_nxt       = r_err;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    // Flipping the sign bits turns a signed compare into unsigned.
                    w_a_nxt      = w_signed_in ? (op_a ^ c_SIGN_MASK) : op_a;
                    w_b_nxt      = w_signed_in ? (op_b ^ c_SIGN_MASK) : op_b;
                    w_funct3_nxt = funct3;
                    w_idx_nxt    = c_IDX_LAST;
                    w_state_nxt  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_illegal) begin
                    // Illegal funct3 spends its single cycle here without comparing.
                    w_err_nxt       = 1'b1;
                    w_taken_nxt     = 1'b0;
                    w_lt_nxt        = 1'b0;
                    w_eq_nxt        = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
                end else if (w_a_slice != w_b_slice) begin
                    w_err_nxt       = 1'b0;
                    w_lt_nxt        = w_slice_lt;
                    w_eq_nxt        = 1'b0;
                    w_taken_nxt     = f_taken(r_funct3, w_slice_lt, 1'b0);
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
                end else if (r_idx == '0) begin
                    w_err_nxt       = 1'b0;
                    w_lt_nxt        = 1'b0;
                    w_eq_nxt        = 1'b1;
                    w_taken_nxt     = f_taken(r_funct3, 1'b0, 1'b1);
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx - c_IDX_W'(1);
                    w_a_nxt   = w_a_shift;
                    w_b_nxt   = w_b_shift;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_comparator_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_comparator_serial
// Brief    : Scoreboard bench for branch_comparator_serial (32/4 and 8/1 builds).
// Revision : 1.0
// ============================================================================
module tb_branch_comparator_serial;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef struct {
        logic taken;
        logic lt;
        logic eq;
        logic err;
        int   acc;
        int   lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1;
    logic [31:0] op_a32 = '0, op_b32 = '0;
    logic [2:0]  funct3_32 = '0;
    logic        taken32, lt32, eq32, err32;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  op_a8 = '0, op_b8 = '0;
    logic [2:0]  funct3_8 = '0;
    logic        taken8, lt8, eq8, err8;

    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;
    logic seen32 = 1'b0, seen8 = 1'b0;

    branch_comparator_serial #(.WIDTH(32), .DIGIT(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .op_a(op_a32), .op_b(op_b32), .funct3(funct3_32), .out_valid(out_valid32),
        .out_ready(out_ready32), .taken(taken32), .lt(lt32), .eq(eq32), .err(err32)
    );

    branch_comparator_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op_a(op_a8), .op_b(op_b8), .funct3(funct3_8), .out_valid(out_valid8),
        .out_ready(out_ready8), .taken(taken8), .lt(lt8), .eq(eq8), .err(err8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: compare on the first cycle each result is presented.
    always @(negedge clk) begin
        if (!rst_n || !out_valid32) begin
            seen32 = 1'b0;
        end else if (!seen32) begin
            seen32 = 1'b1;
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out32: result presented with no request pending (cycle %0d)", cyc);
            end else begin
                m32 = q32.pop_front();
                chk("w32_taken", {31'd0, taken32}, {31'd0, m32.taken});
                chk("w32_lt",    {31'd0, lt32},    {31'd0, m32.lt});
                chk("w32_eq",    {31'd0, eq32},    {31'd0, m32.eq});
                chk("w32_err",   {31'd0, err32},   {31'd0, m32.err});
                chk("w32_latency", cyc - m32.acc, m32.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n || !out_valid8) begin
            seen8 = 1'b0;
        end else if (!seen8) begin
            seen8 = 1'b1;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: result presented with no request pending (cycle %0d)", cyc);
            end else begin
                m8 = q8.pop_front();
                chk("w8_taken", {31'd0, taken8}, {31'd0, m8.taken});
                chk("w8_lt",    {31'd0, lt8},    {31'd0, m8.lt});
                chk("w8_eq",    {31'd0, eq8},    {31'd0, m8.eq});
                chk("w8_err",   {31'd0, err8},   {31'd0, m8.err});
                chk("w8_latency", cyc - m8.acc, m8.lat);
            end
        end
    end

    task automatic send(input bit is8, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic e_tk, input logic e_lt,
                        input logic e_eq, input logic e_er, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        if (is8) begin
            in_valid8 = 1'b1; op_a8 = a[7:0]; op_b8 = b[7:0]; funct3_8 = f3;
        end else begin
            in_valid32 = 1'b1; op_a32 = a; op_b32 = b; funct3_32 = f3;
        end
        n = 0;
        while (!(is8 ? in_ready8 : in_ready32) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never rose (is8=%0d)", is8);
            in_valid8 = 1'b0;
            in_valid32 = 1'b0;
            return;
        end
        e.taken = e_tk; e.lt = e_lt; e.eq = e_eq; e.err = e_er;
        e.acc = cyc + 1; e.lat = lat;
        if (is8) q8.push_back(e); else q32.push_back(e);
        @(negedge clk);
        // Scramble the inputs after accept; captured copies must be used.
        if (is8) begin
            in_valid8 = 1'b0; op_a8 = ~a[7:0]; op_b8 = a[7:0]; funct3_8 = ~f3;
        end else begin
            in_valid32 = 1'b0; op_a32 = ~a; op_b32 = a; funct3_32 = ~f3;
        end
    endtask

    task automatic wait_idle(input bit is8);
        int n = 0;
        while (((is8 ? q8.size() : q32.size()) != 0 || (is8 ? out_valid8 : out_valid32)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: result not delivered (is8=%0d)", is8);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid32}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready32},  32'd1);
        chk("rst_flags",     {28'd0, taken32, lt32, eq32, err32}, 32'd0);
        rst_n = 1'b1;

        //            a             b             f3    tk lt eq er lat
        send(0, 32'h12345678, 32'h12345678, BEQ,  1, 0, 1, 0, 8); wait_idle(0);
        send(0, 32'hFFFFFFFF, 32'h00000001, BLT,  1, 1, 0, 0, 1); wait_idle(0);
        send(0, 32'hFFFFFFFF, 32'h00000001, BLTU, 0, 0, 0, 0, 1); wait_idle(0);
        send(0, 32'h00000010, 32'h00000011, BGE,  0, 1, 0, 0, 8); wait_idle(0);
        send(0, 32'h00000010, 32'h00000011, BNE,  1, 1, 0, 0, 8); wait_idle(0);
        send(0, 32'h80000000, 32'hFFFFFFFF, BLT,  1, 1, 0, 0, 1); wait_idle(0);
        send(0, 32'h12300000, 32'h12400000, BLTU, 1, 1, 0, 0, 3); wait_idle(0);
        send(0, 32'h12345678, 32'h12345679, BGEU, 0, 1, 0, 0, 8); wait_idle(0);
        send(0, 32'h7FFFFFFF, 32'h80000000, BGE,  1, 0, 0, 0, 1); wait_idle(0);
        send(0, 32'hDEADBEEF, 32'hDEADBEEF, BNE,  0, 0, 1, 0, 8); wait_idle(0);
        send(0, 32'h00000000, 32'h00000001, 3'b010, 0, 0, 0, 1, 1); wait_idle(0);
        send(0, 32'h12345678, 32'h12345678, 3'b011, 0, 0, 0, 1, 1); wait_idle(0);

        // Requests offered while busy must be ignored.
        send(0, 32'hCAFEF00D, 32'hCAFEF00D, BEQ, 1, 0, 1, 0, 8);
        in_valid32 = 1'b1; op_a32 = 32'h0; op_b32 = 32'h1; funct3_32 = BLTU;
        repeat (3) @(negedge clk);
        in_valid32 = 1'b0;
        wait_idle(0);

        // Back-pressure: result held while out_ready is low.
        out_ready32 = 1'b0;
        send(0, 32'h00000005, 32'h00000003, BGEU, 1, 0, 0, 0, 8);
        n = 0;
        while (!out_valid32 && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", {31'd0, out_valid32}, 32'd1);
            chk("hold_in_ready",  {31'd0, in_ready32},  32'd0);
            chk("hold_flags",     {28'd0, taken32, lt32, eq32, err32}, 32'b1000);
            @(negedge clk);
        end
        out_ready32 = 1'b1;
        @(negedge clk);
        chk("release_out_valid", {31'd0, out_valid32}, 32'd0);
        chk("release_in_ready",  {31'd0, in_ready32},  32'd1);
        wait_idle(0);

        // Reset mid-SCAN (request never reported).
        @(negedge clk);
        in_valid32 = 1'b1; op_a32 = 32'h11111111; op_b32 = 32'h11111111; funct3_32 = BEQ;
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("scan_rst_out_valid", {31'd0, out_valid32}, 32'd0);
        chk("scan_rst_in_ready",  {31'd0, in_ready32},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("scan_rst_no_stale", {31'd0, out_valid32}, 32'd0);

        // Reset mid-DONE clears the held result at once.
        out_ready32 = 1'b0;
        send(0, 32'h00000000, 32'h00000000, BEQ, 1, 0, 1, 0, 8);
        n = 0;
        while (!out_valid32 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("done_rst_out_valid", {31'd0, out_valid32}, 32'd0);
        chk("done_rst_flags",     {28'd0, taken32, lt32, eq32, err32}, 32'd0);
        chk("done_rst_in_ready",  {31'd0, in_ready32},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready32 = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 32'h00000001, 32'h00000002, BLTU, 1, 1, 0, 0, 8); wait_idle(0);

        // Bit-serial build: WIDTH=8, DIGIT=1
        send(1, 32'h80, 32'h01, BLT,  1, 1, 0, 0, 1); wait_idle(1);
        send(1, 32'h80, 32'h01, BGEU, 1, 0, 0, 0, 1); wait_idle(1);
        send(1, 32'h5A, 32'h5A, BEQ,  1, 0, 1, 0, 8); wait_idle(1);
        send(1, 32'h02, 32'h03, BGE,  0, 1, 0, 0, 8); wait_idle(1);

        chk("q32_drained", q32.size(), 32'd0);
        chk("q8_drained",  q8.size(),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
